// File: rtl/wb_cpu_bus_if_pkg.sv
// Shared definitions for the CPU-to-Wishbone data port adapter.
package wb_cpu_bus_if_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    BUSY       = 2'b01,
    WAIT_STALL = 2'b10
  } bus_state_t;

  // Position of the MEM stage inside the ctrl stall vector
  localparam int STALL_MEM = 4;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;

endpackage

// File: rtl/wb_cpu_bus_if.sv
// Wishbone classic master sitting between the MEM stage data port and the
// system bus. A single-cycle CPU request becomes a registered bus cycle; the
// pipeline is stalled until ack, flush or timeout, and read data is held
// while the pipeline remains stalled for unrelated reasons.
module wb_cpu_bus_if
  import wb_cpu_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);

  // Last counter value before the cycle is aborted; irrelevant when disabled
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  bus_state_t        state_q, state_d;
  logic [31:0]       rd_buf;
  logic [CNT_W-1:0]  cnt;
  logic              new_req;
  logic              timeout_fire;
  logic              mem_stall;
  logic              unused_stall;

  assign mem_stall    = stall_i[STALL_MEM];
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};
  assign new_req      = (cpu_ce_i == CHIP_ENABLE) && !flush_i;
  assign timeout_fire = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i == RST_ENABLE) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the combinational stall request and load data
  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (new_req) begin
          state_d    = BUSY;
          stallreq_o = 1'b1;
        end
      end
      BUSY: begin
        stallreq_o = !(wb_ack_i || timeout_fire);
        if (wb_ack_i && !wb_we_o) begin
          cpu_data_o = wb_dat_i;
        end
        if (flush_i) begin
          state_d = IDLE;
        end else if (wb_ack_i) begin
          state_d = mem_stall ? WAIT_STALL : IDLE;
        end else if (timeout_fire) begin
          state_d = IDLE;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (!mem_stall || flush_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs, read buffer, timeout counter and error pulse
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i == RST_ENABLE) begin
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'h0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      err_o    <= 1'b0;
      rd_buf   <= 32'h0;
      cnt      <= '0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (new_req) begin
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            cnt      <= '0;
          end else begin
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
          end
        end
        BUSY: begin
          if (flush_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            rd_buf   <= 32'h0;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            if (!wb_we_o) begin
              rd_buf <= wb_dat_i;
            end
          end else if (timeout_fire) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            rd_buf   <= 32'h0;
            err_o    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cpu_bus_if.sv
// Directed bench for wb_cpu_bus_if with a scoreboard on completed bus cycles.
module tb_wb_cpu_bus_if;

  typedef struct {
    bit          is_err;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'h0;
  logic        flush = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        err_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  logic        slave_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] slave_data = 32'h0;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];

  wb_cpu_bus_if #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .stall_i(stall), .flush_i(flush),
    .cpu_ce_i(ce), .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_we_i(we),
    .cpu_sel_i(sel), .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .err_o(err_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  // Slave model: acks after ack_delay wait states, returns slave_data
  assign wb_ack_i = slave_en && wb_cyc_o && wb_stb_o && (wait_cnt == ack_delay);
  assign wb_dat_i = slave_data;

  // Wait-state counter restarts whenever no strobe is pending
  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic [3:0] s, input int kind, input logic [31:0] rd);
    exp_t e;
    ce    = 1'b1;
    addr  = a;
    wdata = d;
    we    = w;
    sel   = s;
    if (kind != 0) begin
      e.is_err = (kind == 2);
      e.adr    = a;
      e.we     = w;
      e.sel    = s;
      e.wdat   = d;
      e.rdata  = rd;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed (acked) or aborted cycle is matched against the queue
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((wb_cyc_o && wb_stb_o && wb_ack_i && !flush) || err_o)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL sb_unexpected: got completion with empty queue at %0t", $time);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_kind_is_err", {31'h0, err_o}, {31'h0, e.is_err});
        if (!e.is_err) begin
          checkOutput("sb_adr", wb_adr_o, e.adr);
          checkOutput("sb_we", {31'h0, wb_we_o}, {31'h0, e.we});
          checkOutput("sb_sel", {28'h0, wb_sel_o}, {28'h0, e.sel});
          if (e.we) checkOutput("sb_wdat", wb_dat_o, e.wdat);
        end
        checkOutput("sb_cpu_data", cpu_data_o, e.rdata);
        checkOutput("sb_stallreq", {31'h0, stallreq_o}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    step();
    step();
    @(negedge clk);
    checkOutput("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    checkOutput("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    checkOutput("rst_we", {31'h0, wb_we_o}, 32'h0);
    checkOutput("rst_sel", {28'h0, wb_sel_o}, 32'h0);
    checkOutput("rst_adr", wb_adr_o, 32'h0);
    checkOutput("rst_dat", wb_dat_o, 32'h0);
    checkOutput("rst_err", {31'h0, err_o}, 32'h0);
    checkOutput("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
    checkOutput("rst_cpu_data", cpu_data_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // 1: zero-wait read
    $display("[TB] test 1: zero-wait read");
    ack_delay = 0;
    slave_data = 32'hDEAD_BEEF;
    applyStimulus(32'h10, 32'h0, 1'b0, 4'hF, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("t1_req_stallreq", {31'h0, stallreq_o}, 32'h1);
    step();
    ce = 1'b0;
    @(negedge clk);
    checkOutput("t1_cyc", {31'h0, wb_cyc_o}, 32'h1);
    checkOutput("t1_adr", wb_adr_o, 32'h10);
    checkOutput("t1_stallreq", {31'h0, stallreq_o}, 32'h0);
    checkOutput("t1_cpu_data", cpu_data_o, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    checkOutput("t1_cyc_after", {31'h0, wb_cyc_o}, 32'h0);
    step();

    // 2: write with 3 wait states
    $display("[TB] test 2: write, 3 wait states");
    ack_delay = 3;
    applyStimulus(32'h104, 32'h1234_5678, 1'b1, 4'b0011, 1, 32'h0);
    @(negedge clk);
    checkOutput("t2_req_stallreq", {31'h0, stallreq_o}, 32'h1);
    step();
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t2_we", {31'h0, wb_we_o}, 32'h1);
      checkOutput("t2_sel", {28'h0, wb_sel_o}, 32'h3);
      checkOutput("t2_adr", wb_adr_o, 32'h104);
      checkOutput("t2_cpu_data", cpu_data_o, 32'h0);
      checkOutput("t2_stallreq", {31'h0, stallreq_o}, (i < 3) ? 32'h1 : 32'h0);
      step();
    end
    @(negedge clk);
    checkOutput("t2_cyc_after", {31'h0, wb_cyc_o}, 32'h0);
    checkOutput("t2_cpu_data_after", cpu_data_o, 32'h0);
    step();

    // 3: read acked while MEM is stalled
    $display("[TB] test 3: read into held pipeline stall");
    ack_delay = 0;
    slave_data = 32'hA5A5_0F0F;
    stall = 6'b010000;
    applyStimulus(32'h200, 32'h0, 1'b0, 4'hF, 1, 32'hA5A5_0F0F);
    step();
    ce = 1'b0;
    step();
    slave_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t3_hold_data", cpu_data_o, 32'hA5A5_0F0F);
      checkOutput("t3_hold_stallreq", {31'h0, stallreq_o}, 32'h0);
      checkOutput("t3_hold_cyc", {31'h0, wb_cyc_o}, 32'h0);
      if (i < 2) step();
    end
    step();
    stall = 6'h0;
    step();
    @(negedge clk);
    checkOutput("t3_idle_data", cpu_data_o, 32'h0);
    step();

    // 4: flush in the second busy cycle
    $display("[TB] test 4: flush during read");
    ack_delay = 5;
    applyStimulus(32'h300, 32'h0, 1'b0, 4'hF, 0, 32'h0);
    step();
    ce = 1'b0;
    @(negedge clk);
    checkOutput("t4_busy_stallreq", {31'h0, stallreq_o}, 32'h1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_cyc", {31'h0, wb_cyc_o}, 32'h0);
    checkOutput("t4_stb", {31'h0, wb_stb_o}, 32'h0);
    checkOutput("t4_cpu_data", cpu_data_o, 32'h0);
    checkOutput("t4_err", {31'h0, err_o}, 32'h0);
    step();

    // 5: timeout, slave silent
    $display("[TB] test 5: timeout");
    slave_en = 1'b0;
    applyStimulus(32'h400, 32'h0, 1'b0, 4'hF, 2, 32'h0);
    step();
    ce = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("t5_busy_cyc", {31'h0, wb_cyc_o}, 32'h1);
      checkOutput("t5_busy_err", {31'h0, err_o}, 32'h0);
      checkOutput("t5_busy_stallreq", {31'h0, stallreq_o}, (i < 15) ? 32'h1 : 32'h0);
      step();
    end
    @(negedge clk);
    checkOutput("t5_abort_cyc", {31'h0, wb_cyc_o}, 32'h0);
    checkOutput("t5_abort_err", {31'h0, err_o}, 32'h1);
    checkOutput("t5_abort_stallreq", {31'h0, stallreq_o}, 32'h0);
    checkOutput("t5_abort_data", cpu_data_o, 32'h0);
    step();
    @(negedge clk);
    checkOutput("t5_err_pulse_end", {31'h0, err_o}, 32'h0);
    step();

    // 6: reset during busy, then a normal read
    $display("[TB] test 6: reset mid-cycle");
    applyStimulus(32'h500, 32'hFFFF_0000, 1'b1, 4'hF, 0, 32'h0);
    step();
    ce = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_busy_cyc", {31'h0, wb_cyc_o}, 32'h1);
    step();
    rst = 1'b0;
    slave_en = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    checkOutput("t6_rst_stb", {31'h0, wb_stb_o}, 32'h0);
    checkOutput("t6_rst_we", {31'h0, wb_we_o}, 32'h0);
    checkOutput("t6_rst_adr", wb_adr_o, 32'h0);
    checkOutput("t6_rst_stallreq", {31'h0, stallreq_o}, 32'h0);
    step();
    ack_delay = 0;
    slave_data = 32'h0BAD_F00D;
    applyStimulus(32'h20, 32'h0, 1'b0, 4'hF, 1, 32'h0BAD_F00D);
    step();
    ce = 1'b0;
    @(negedge clk);
    checkOutput("t6_read_cpu_data", cpu_data_o, 32'h0BAD_F00D);
    step();

    // 7: back-to-back requests keep a one-cycle gap
    $display("[TB] test 7: back-to-back reads");
    slave_data = 32'h1111_2222;
    applyStimulus(32'h600, 32'h0, 1'b0, 4'hF, 1, 32'h1111_2222);
    step();
    applyStimulus(32'h604, 32'h0, 1'b0, 4'hF, 1, 32'h3333_4444);
    @(negedge clk);
    checkOutput("t7_first_adr", wb_adr_o, 32'h600);
    step();
    slave_data = 32'h3333_4444;
    @(negedge clk);
    checkOutput("t7_gap_cyc", {31'h0, wb_cyc_o}, 32'h0);
    checkOutput("t7_gap_stallreq", {31'h0, stallreq_o}, 32'h1);
    step();
    ce = 1'b0;
    @(negedge clk);
    checkOutput("t7_second_cyc", {31'h0, wb_cyc_o}, 32'h1);
    checkOutput("t7_second_adr", wb_adr_o, 32'h604);
    step();
    step();

    checkOutput("sb_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
